// File: rtl/key_debounce_multi.sv
// ---------------------------------------------------------------------------
// key_debounce_multi
//
// Multi-channel push-button conditioner for the stopwatch front panel.
// Each raw key is polarity-corrected, passed through a two-flop synchroniser
// and debounced independently. For every key the block produces a clean
// pressed level plus one-cycle press, release, long-press and auto-repeat
// pulses, so the control FSM downstream needs no edge detection of its own.
//
// Ports:
//   clk          system clock (1 kHz in the stopwatch build)
//   sys_rst_n    asynchronous active-low reset. Assertion is asynchronous.
//                Release is expected to be synchronous to clk already.
//   key_in       raw asynchronous key inputs, bit i = key i
//   key_level    debounced pressed state, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
//   key_long     one-cycle pulse once per press after LONG_CYC cycles held
//   key_rep      one-cycle auto-repeat pulse every REPEAT_CYC after key_long
//   key_any      registered OR of all debounced levels
// ---------------------------------------------------------------------------
module key_debounce_multi #(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 10,
    parameter int LONG_CYC     = 1000,
    parameter int REPEAT_CYC   = 200,
    parameter int REPEAT_EN    = 1,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_rep,
    output logic              key_any
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(LONG_CYC + REPEAT_CYC + 1);
    localparam int REP_W  = $clog2(REPEAT_CYC + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    localparam logic [N_KEYS-1:0] POL_MASK   = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
    localparam logic              REP_ENABLE = (REPEAT_EN != 0);

    logic [N_KEYS-1:0]             sync_meta_q, sync_meta_d;
    logic [N_KEYS-1:0]             sync_q,      sync_d;
    logic [N_KEYS-1:0]             level_q,     level_d;
    logic [N_KEYS-1:0][DB_W-1:0]   db_cnt_q,    db_cnt_d;
    logic [N_KEYS-1:0][HOLD_W-1:0] hold_q,      hold_d;
    logic [N_KEYS-1:0][REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
    logic [N_KEYS-1:0]             press_q,     press_d;
    logic [N_KEYS-1:0]             release_q,   release_d;
    logic [N_KEYS-1:0]             long_q,      long_d;
    logic [N_KEYS-1:0]             rep_q,       rep_d;
    logic                          any_q,       any_d;

    // Next-state logic for every channel. The pulses are computed from the
    // next level against the current one, so they register on the same edge
    // as the level change itself.
    always_comb begin
        sync_meta_d = key_in ^ POL_MASK;
        sync_d      = sync_meta_q;
        level_d     = level_q;
        db_cnt_d    = '0;
        hold_d      = '0;
        rep_cnt_d   = '0;
        long_d      = '0;
        rep_d       = '0;

        for (int i = 0; i < N_KEYS; i++) begin
            // A differing sample advances the count, any agreeing sample
            // leaves it at zero, so only an unbroken run can flip the level.
            if (sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
                end
            end

            // Hold counter is zero on the rising edge of the level and
            // saturates at LONG_CYC; from then on the repeat counter wraps
            // every REPEAT_CYC. Both clear whenever the level is (or goes) low.
            if (level_d[i] && level_q[i]) begin
                if (hold_q[i] != HOLD_LONG) begin
                    hold_d[i] = hold_q[i] + HOLD_ONE;
                    long_d[i] = (hold_q[i] == HOLD_PRE);
                end else begin
                    hold_d[i] = hold_q[i];
                    if (rep_cnt_q[i] == REP_LAST) begin
                        rep_cnt_d[i] = '0;
                        rep_d[i]     = REP_ENABLE;
                    end else begin
                        rep_cnt_d[i] = rep_cnt_q[i] + REP_ONE;
                    end
                end
            end
        end

        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
        any_d     = |level_d;
    end

    // State and output registers. Reset drops every output at once, so a
    // key held through reset is simply pressed again afresh, with no release.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            level_q     <= '0;
            db_cnt_q    <= '0;
            hold_q      <= '0;
            rep_cnt_q   <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            rep_q       <= '0;
            any_q       <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            level_q     <= level_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            rep_cnt_q   <= rep_cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            rep_q       <= rep_d;
            any_q       <= any_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_rep     = rep_q;
    assign key_any     = any_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_key_debounce_multi
//
// Directed bench for key_debounce_multi. Three instances share clock and
// reset: dut_a (repeat enabled, active-high), dut_b (repeat disabled) and
// dut_c (active-low inputs). All use DEBOUNCE_CYC=10, LONG_CYC=50,
// REPEAT_CYC=20. Inputs change on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_key_debounce_multi;

    logic       clk;
    logic       sys_rst_n;
    logic [3:0] key_a, key_b, key_c;
    logic [3:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
    logic [3:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
    logic [3:0] lvl_c, prs_c, rel_c, lng_c, rep_c;
    logic       any_a, any_b, any_c;

    int n_checks;
    int n_pass;
    int c_pulse_cnt;

    key_debounce_multi #(
        .N_KEYS(4), .DEBOUNCE_CYC(10), .LONG_CYC(50), .REPEAT_CYC(20),
        .REPEAT_EN(1), .ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .sys_rst_n(sys_rst_n), .key_in(key_a),
        .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
        .key_long(lng_a), .key_rep(rep_a), .key_any(any_a)
    );

    key_debounce_multi #(
        .N_KEYS(4), .DEBOUNCE_CYC(10), .LONG_CYC(50), .REPEAT_CYC(20),
        .REPEAT_EN(0), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .sys_rst_n(sys_rst_n), .key_in(key_b),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
        .key_long(lng_b), .key_rep(rep_b), .key_any(any_b)
    );

    key_debounce_multi #(
        .N_KEYS(4), .DEBOUNCE_CYC(10), .LONG_CYC(50), .REPEAT_CYC(20),
        .REPEAT_EN(1), .ACTIVE_LOW(1)
    ) dut_c (
        .clk(clk), .sys_rst_n(sys_rst_n), .key_in(key_c),
        .key_level(lvl_c), .key_press(prs_c), .key_release(rel_c),
        .key_long(lng_c), .key_rep(rep_c), .key_any(any_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every cycle in which dut_c shows any pulse.
    always @(negedge clk) begin
        if (|{prs_c, rel_c, lng_c, rep_c}) c_pulse_cnt <= c_pulse_cnt + 1;
    end

    // Reset values of all three instances, then idle active-low inputs.
    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_a = 4'b0000;
        key_b = 4'b0000;
        key_c = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, prs_a, rel_a, lng_a, rep_a, any_a} !== 21'd0)
            $display("[TB] FAIL reset_a: got %b, expected all zero", {lvl_a, prs_a, rel_a, lng_a, rep_a, any_a});
        else n_pass++;
        n_checks++;
        if ({lvl_b, prs_b, rel_b, lng_b, rep_b, any_b} !== 21'd0)
            $display("[TB] FAIL reset_b: got %b, expected all zero", {lvl_b, prs_b, rel_b, lng_b, rep_b, any_b});
        else n_pass++;
        n_checks++;
        if ({lvl_c, prs_c, rel_c, lng_c, rep_c, any_c} !== 21'd0)
            $display("[TB] FAIL reset_c: got %b, expected all zero", {lvl_c, prs_c, rel_c, lng_c, rep_c, any_c});
        else n_pass++;
        @(negedge clk);
        sys_rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_c, any_c} !== 5'd0)
            $display("[TB] FAIL idle_active_low: got %b, expected 00000", {lvl_c, any_c});
        else n_pass++;
    endtask

    // Clean press and release of key0: both accepted on the 12th edge.
    task automatic test_single_press();
        @(negedge clk);
        key_a[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, prs_a, any_a} !== 9'd0)
            $display("[TB] FAIL press_edge11: got %b, expected 000000000", {lvl_a, prs_a, any_a});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, prs_a, any_a} !== {4'b0001, 4'b0001, 1'b1})
            $display("[TB] FAIL press_edge12: got %b, expected 000100011", {lvl_a, prs_a, any_a});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, prs_a} !== {4'b0001, 4'b0000})
            $display("[TB] FAIL press_edge13: got %b, expected 00010000", {lvl_a, prs_a});
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        key_a[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, rel_a} !== {4'b0001, 4'b0000})
            $display("[TB] FAIL release_edge11: got %b, expected 00010000", {lvl_a, rel_a});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_a, rel_a, any_a} !== {4'b0000, 4'b0001, 1'b0})
            $display("[TB] FAIL release_edge12: got %b, expected 000000010", {lvl_a, rel_a, any_a});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({rel_a, lng_a, rep_a} !== 12'd0)
            $display("[TB] FAIL release_edge13: got %b, expected all zero", {rel_a, lng_a, rep_a});
        else n_pass++;
    endtask

    // Bouncy press: 1x5, 0x3, 1x8, 0x2, then 1x30. Only the final rise counts.
    task automatic test_bounce();
        int         seg_len [5];
        logic [4:0] seg_val;
        int         n;
        seg_len = '{5, 3, 8, 2, 30};
        seg_val = 5'b10101;
        n = 0;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < seg_len[s]; c++) begin
                @(negedge clk);
                key_a[0] = seg_val[s];
                @(posedge clk);
                #1;
                n++;
                n_checks++;
                if (prs_a !== ((n == 30) ? 4'b0001 : 4'b0000))
                    $display("[TB] FAIL bounce_press edge %0d: got %b, expected %b", n, prs_a, (n == 30) ? 4'b0001 : 4'b0000);
                else n_pass++;
                n_checks++;
                if ({rel_a, lvl_a[0]} !== {4'b0000, (n >= 30)})
                    $display("[TB] FAIL bounce_level edge %0d: got %b, expected %b", n, {rel_a, lvl_a[0]}, {4'b0000, (n >= 30)});
                else n_pass++;
            end
        end
        @(negedge clk);
        key_a[0] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if ({rel_a, lng_a} !== {4'b0001, 4'b0000})
            $display("[TB] FAIL bounce_release: got %b, expected 00010000", {rel_a, lng_a});
        else n_pass++;
        repeat (2) @(posedge clk);
    endtask

    // 150-cycle hold on key1 of dut_a (repeat on) and dut_b (repeat off).
    task automatic test_long_repeat();
        logic [3:0] exp_long, exp_rep, exp_rel;
        @(negedge clk);
        key_a[1] = 1'b1;
        key_b[1] = 1'b1;
        repeat (11) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({prs_a, prs_b} !== {4'b0010, 4'b0010})
            $display("[TB] FAIL long_press_E: got %b, expected 00100010", {prs_a, prs_b});
        else n_pass++;
        for (int j = 1; j <= 160; j++) begin
            @(posedge clk);
            #1;
            exp_long = (j == 50) ? 4'b0010 : 4'b0000;
            exp_rep  = (j >= 70 && j < 150 && ((j - 50) % 20) == 0) ? 4'b0010 : 4'b0000;
            exp_rel  = (j == 150) ? 4'b0010 : 4'b0000;
            n_checks++;
            if ({lng_a, rep_a, rel_a, lvl_a[1]} !== {exp_long, exp_rep, exp_rel, (j < 150)})
                $display("[TB] FAIL repeat_a E+%0d: got %b, expected %b", j,
                         {lng_a, rep_a, rel_a, lvl_a[1]}, {exp_long, exp_rep, exp_rel, (j < 150)});
            else n_pass++;
            n_checks++;
            if ({lng_b, rep_b, rel_b, lvl_b[1]} !== {exp_long, 4'b0000, exp_rel, (j < 150)})
                $display("[TB] FAIL norepeat_b E+%0d: got %b, expected %b", j,
                         {lng_b, rep_b, rel_b, lvl_b[1]}, {exp_long, 4'b0000, exp_rel, (j < 150)});
            else n_pass++;
            if (j == 138) begin
                @(negedge clk);
                key_a[1] = 1'b0;
                key_b[1] = 1'b0;
            end
        end
    endtask

    // Keys 0 and 3 pressed on the same cycle.
    task automatic test_simultaneous();
        @(negedge clk);
        key_a = 4'b1001;
        repeat (11) @(posedge clk);
        #1;
        n_checks++;
        if ({prs_a, any_a} !== 5'b00000)
            $display("[TB] FAIL simul_edge11: got %b, expected 00000", {prs_a, any_a});
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({prs_a, lvl_a, any_a} !== {4'b1001, 4'b1001, 1'b1})
            $display("[TB] FAIL simul_press: got %b, expected 100110011", {prs_a, lvl_a, any_a});
        else n_pass++;
        @(negedge clk);
        key_a = 4'b0000;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if ({rel_a, any_a} !== {4'b1001, 1'b0})
            $display("[TB] FAIL simul_release: got %b, expected 10010", {rel_a, any_a});
        else n_pass++;
        repeat (2) @(posedge clk);
    endtask

    // Active-low instance: idle without pulses, then reset while key2 held.
    task automatic test_active_low_reset();
        int snap;
        n_checks++;
        if (c_pulse_cnt !== 0)
            $display("[TB] FAIL al_idle_pulses: got %0d, expected 0", c_pulse_cnt);
        else n_pass++;
        @(negedge clk);
        key_c[2] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (prs_c !== 4'b0100)
            $display("[TB] FAIL al_press: got %b, expected 0100", prs_c);
        else n_pass++;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if ({lvl_c, any_c} !== {4'b0100, 1'b1})
            $display("[TB] FAIL al_held: got %b, expected 01001", {lvl_c, any_c});
        else n_pass++;
        @(negedge clk);
        sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({lvl_c, prs_c, rel_c, lng_c, rep_c, any_c} !== 21'd0)
            $display("[TB] FAIL al_async_reset: got %b, expected all zero", {lvl_c, prs_c, rel_c, lng_c, rep_c, any_c});
        else n_pass++;
        snap = c_pulse_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({prs_c, rel_c} !== {((n == 12) ? 4'b0100 : 4'b0000), 4'b0000})
                $display("[TB] FAIL al_repress edge %0d: got %b, expected %b", n,
                         {prs_c, rel_c}, {((n == 12) ? 4'b0100 : 4'b0000), 4'b0000});
            else n_pass++;
        end
        n_checks++;
        if ((c_pulse_cnt - snap) !== 1)
            $display("[TB] FAIL al_pulse_count: got %0d, expected 1", c_pulse_cnt - snap);
        else n_pass++;
        @(negedge clk);
        key_c[2] = 1'b1;
        repeat (14) @(posedge clk);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        c_pulse_cnt = 0;
        test_reset();
        test_single_press();
        test_bounce();
        test_long_repeat();
        test_simultaneous();
        test_active_low_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
